// File: rtl/pipeline_f.sv
// ---------------------------------------------------------------------------
// pipeline_f -- fetch stage of the 5-stage MIPS pipeline.
//
// Holds the PC, issues instruction-memory requests over a valid/ack
// handshake, buffers one returned instruction while decode is stalled and
// handles branch/jump redirects. A redirect that arrives while a fetch is
// still unacknowledged moves to DROP, which keeps the old request stable
// until its ack and then throws the data away.
//
// Optional feature (macro PIPELINE_F_ALIGN_CHECK_EN):
//   adds output f_adel. A misaligned PC (reachable only through a redirect)
//   issues no request and presents a valid NOP with f_adel=1 until the next
//   redirect. Without the macro the low two bits of redirect_pc are dropped.
//
// Ports
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   f_stall      in   decode not accepting; F output must hold
//   redirect     in   taken branch/jump; current F instruction is wrong-path
//   redirect_pc  in   redirect target
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address
//   imem_ack     in   request accepted, imem_rdata valid this cycle
//   imem_rdata   in   instruction word
//   f_inst       out  instruction for D (0 when f_valid=0)
//   f_p4         out  pc+4
//   dbg_f_pc     out  pc
//   f_valid      out  f_inst is a real instruction for pc
//   f_adel       out  address-error on fetch (macro builds only)
// ---------------------------------------------------------------------------
//  state | meaning
//  BOOT  | one idle cycle after reset, no request
//  REQ   | requesting imem at pc; F output valid in the ack cycle
//  HOLD  | instruction for pc is in buf_q, waiting for decode
//  DROP  | wrong-path fetch at drop_addr_q outstanding, discard on ack
// ---------------------------------------------------------------------------
module pipeline_f #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        f_stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] f_inst,
   output logic [31:0] f_p4,
   output logic [31:0] dbg_f_pc,
   output logic        f_valid
`ifdef PIPELINE_F_ALIGN_CHECK_EN
   ,
   output logic        f_adel
`endif
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] drop_addr_q, drop_addr_d;

   logic        in_req, in_hold, in_drop;
   logic        pc_mis;
   logic [31:0] redirect_tgt;
   logic [31:0] pc_plus4;

   assign in_req  = (state_q == ST_REQ);
   assign in_hold = (state_q == ST_HOLD);
   assign in_drop = (state_q == ST_DROP);

   assign pc_plus4 = pc_q + 32'd4;

`ifdef PIPELINE_F_ALIGN_CHECK_EN
   assign pc_mis       = (pc_q[1:0] != 2'b00);
   assign redirect_tgt = redirect_pc;
`else
   // Low bits are masked so the PC can never become misaligned.
   assign pc_mis       = 1'b0;
   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      imem_req  = in_drop | (in_req & ~pc_mis);
      imem_addr = in_drop ? drop_addr_q : pc_q;
      // A misaligned PC presents a valid (faulting) NOP without memory.
      f_valid   = ~redirect & ((in_req & (imem_ack | pc_mis)) | in_hold);
      if (!f_valid) begin
         f_inst = 32'h0000_0000;
      end else if (in_hold) begin
         f_inst = buf_q;
      end else if (pc_mis) begin
         f_inst = 32'h0000_0000;
      end else begin
         f_inst = imem_rdata;
      end
      f_p4     = pc_plus4;
      dbg_f_pc = pc_q;
   end

`ifdef PIPELINE_F_ALIGN_CHECK_EN
   assign f_adel = f_valid & in_req & pc_mis;
`endif

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_d       = buf_q;
      drop_addr_d = drop_addr_q;

      if (redirect) begin
         // Redirect wins over stall and over normal sequencing.
         pc_d = redirect_tgt;
         case (state_q)
            ST_REQ: begin
               if (imem_req && !imem_ack) begin
                  state_d     = ST_DROP;
                  drop_addr_d = pc_q;
               end else begin
                  state_d = ST_REQ;
               end
            end
            ST_HOLD: state_d = ST_REQ;
            ST_DROP: state_d = ST_DROP;
            default: state_d = ST_BOOT;
         endcase
      end else begin
         case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
               if (pc_mis) begin
                  state_d = ST_REQ;
               end else if (imem_ack && !f_stall) begin
                  pc_d = pc_plus4;
               end else if (imem_ack) begin
                  buf_d   = imem_rdata;
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!f_stall) begin
                  pc_d    = pc_plus4;
                  state_d = ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem_ack) begin
                  state_d = ST_REQ;
               end
            end
            default: state_d = ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         buf_q       <= 32'h0000_0000;
         drop_addr_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_q       <= buf_d;
         drop_addr_q <= drop_addr_d;
      end
   end

endmodule

// File: doc/pipeline_f.md
# pipeline_F

Fetch stage for the 5-stage MIPS pipeline and the producer side of the D-stage pipeline register. Holds the PC and issues instruction-memory requests over a valid/ack handshake. Buffers one returned instruction while decode is stalled and handles branch/jump redirects, including discarding an in-flight wrong-path fetch. It drives `f_inst`/`f_p4`/`dbg_f_pc` into the D register and `f_valid`, which the hazard unit turns into `d_bubble`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `f_stall`  in  1  decode not accepting; the F output must hold.
- `redirect`  in  1  taken branch/jump; the current F instruction is wrong-path.
- `redirect_pc`  in  32  redirect target.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, word-aligned.
- `imem_ack`  in  1  memory accepted the request and `imem_rdata` is valid this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `f_inst`  out  32  instruction for D; 0 (NOP) when `f_valid`=0.
- `f_p4`  out  32  `pc`+4.
- `dbg_f_pc`  out  32  `pc`.
- `f_valid`  out  1  `f_inst` is a real instruction for `pc`.

## Operation
- **Registers:** `pc`[31:0], `state` ∈ {BOOT, REQ, HOLD, DROP}, `buf`[31:0].
- **`imem_addr` mapping:** `imem_addr`=`pc` in BOOT/REQ/HOLD. In DROP it is the held old address `drop_addr`.
- **`imem_req`:** 1 in REQ and DROP, otherwise 0. Once `imem_req` is asserted, the request stays stable until `imem_ack`.
- **`f_valid`:** 1 if (REQ & `imem_ack`) or HOLD, and forced to 0 when `redirect`=1.
- **`f_inst`:** `imem_rdata` in REQ, `buf` in HOLD, 0 otherwise or when `f_valid`=0.
- **BOOT:** go to REQ next cycle.
- **REQ:**
  - `ack` & !`stall` → `pc`+=4, stay in REQ.
  - `ack` & `stall` → `buf`<=`imem_rdata`, go to HOLD.
  - No `ack` → stay in REQ.
- **HOLD:** !`stall` → `pc`+=4, go to REQ. Otherwise stay in HOLD.
- **DROP:** `ack` → discard the data and go to REQ.
- **Redirect (overrides all of the above):** `pc`<=`redirect_pc`, and:
  - REQ without `ack` → DROP, capturing `drop_addr`=old `pc`.
  - REQ with `ack` → REQ; the data is discarded.
  - HOLD → REQ.
  - DROP → DROP, with `pc` updated.
  - BOOT → BOOT, with `pc` updated.
- **Stall vs. redirect:** `f_stall` never blocks a redirect.
- **Arithmetic:** `pc`+4 is 32-bit and wraps from 32'hFFFF_FFFC to 0.

## Timing
- **Reset values:** `pc`=`RESET_PC`, state BOOT, `buf`=0. Outputs: `imem_req`=0, `f_valid`=0, `f_inst`=0, `imem_addr`=`dbg_f_pc`=`RESET_PC`, `f_p4`=`RESET_PC`+4.
- **First request:** appears in the first cycle after `resetn` is released plus one BOOT cycle.
- **Throughput:** with zero-wait memory (`ack` in the request cycle), one instruction per cycle.
- **Latency:** the F output is valid in the `ack` cycle.
- **Redirect recovery:** with no outstanding fetch, the first request to the target is issued the cycle after `redirect`. With an outstanding fetch, that request waits for the old `ack` plus one cycle.
- **Reset mid-fetch:** an outstanding request is abandoned; memory must tolerate this.

## Configuration
- **`PIPELINE_F_ALIGN_CHECK_EN` defined:**
  - Adds output `f_adel`.
  - If `pc`[1:0]≠0 (from a redirect), no `imem_req` is issued, `f_valid`=1, `f_inst`=0 and `f_adel`=1.
  - This holds until the next `redirect`; a D handoff (!`f_stall`) does not advance `pc`.
  - `f_adel` resets to 0.
- **Not defined:** `redirect_pc`[1:0] is ignored and loaded as 00; there is no `f_adel` port.

## Test plan
- **Reset and boot:** `RESET_PC`=32'h0040_0000, memory acks at once → `imem_req`=0 for 1 cycle after reset release, then addresses 0x400000, 0x400004, 0x400008 on consecutive cycles with `f_valid`=1 each cycle.
- **Stall:** `f_stall` held 3 cycles while fetching 0x400004 (data 0x2408_0005) → HOLD, `imem_req`=0, `f_inst` held at 0x2408_0005 and `dbg_f_pc`=0x400004 for all 3 cycles. When the stall is released, the next address is 0x400008.
- **Wait states:** `ack` delayed by 2 cycles → `imem_addr` stable and `f_valid`=0 for 2 cycles, then `f_valid`=1 in the `ack` cycle.
- **Redirect during an outstanding fetch:** `redirect`=1 with `redirect_pc`=0x400100 while the fetch of 0x400008 is unacked → `imem_addr` stays 0x400008 until `ack`, the data is discarded (`f_valid`=0), and the next request is 0x400100.
- **Redirect with stall:** `redirect` and `f_stall` both 1 in HOLD → `f_valid`=0 that cycle, the buffer is dropped, and the next request is to the target.
- **Misaligned target (macro on):** `redirect_pc`=0x400102 → no request, `f_adel`=1, `f_inst`=0, `dbg_f_pc`=0x400102. With the macro off, the same stimulus fetches 0x400100.
